multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main sequencer for the multi-cycle CPU: Moore FSM that walks each instruction through
//  fetch/decode/execute/memory/writeback and drives every datapath select and enable.
//  It supplies aluop to ALU_Control (3'b000 add, 3'b001 sub, 3'b100 decode funct) and
//  waits on memory through a memready handshake. Sits beside the datapath, one per core.
// PARAMETERS
//  OP_RTYPE  6'h00  opcode of R-type (ALU op from funct)
//  OP_LW     6'h23  load word
//  OP_SW     6'h2B  store word
//  OP_BEQ    6'h04  branch if equal
//  OP_J      6'h02  jump
//  OP_ADDI   6'h08  add immediate
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  opcode      in   6  instr[31:26] from instruction register (stable after FETCH)
//  memready    in   1  memory completes current access this cycle
//  zero        in   1  ALU zero flag (current cycle)
//  pcen        out  1  PC load enable = pcwrite | (pcwritecond & zero)
//  iord        out  1  memory address select: 0 PC, 1 ALUOut
//  memread     out  1  memory read request
//  memwrite    out  1  memory write request
//  irwrite     out  1  instruction register load
//  memtoreg    out  1  reg write data: 0 ALUOut, 1 MDR
//  regdst      out  1  reg write address: 0 rt, 1 rd
//  regwrite    out  1  register file write enable
//  alusrca     out  1  ALU A: 0 PC, 1 reg A
//  alusrcb     out  2  ALU B: 00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  pcsrc       out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//  aluop       out  3  to ALU_Control
//  instr_done  out  1  1-cycle pulse in the last cycle of each retired instruction
//  illegal_op  out  1  1-cycle pulse in DECODE when opcode is none of the six
// BEHAVIOUR
//  - State reg 4 bits; rst_n low -> RESET immediately; every output 0 in RESET
//    (aluop 000, selects 00). RESET -> FETCH unconditionally next cycle.
//  - Outputs purely from state (+memready/zero where stated); unlisted outputs = 0.
//  - FETCH: memread, alusrcb=01, aluop=000; irwrite=pcen=memready; stay until memready.
//  - DECODE: alusrcb=11, aluop=000 (branch target to ALUOut). Next: RTYPE->RTEXEC,
//    LW/SW->MEMADR, BEQ->BRANCH, J->JUMP, ADDI->ADDIEXEC, other->FETCH + illegal_op.
//  - MEMADR: alusrca=1, alusrcb=10, aluop=000 -> MEMRD if LW else MEMWR.
//  - MEMRD: memread, iord=1; hold until memready -> MEMWB.
//  - MEMWB: regwrite, memtoreg=1, regdst=0, instr_done -> FETCH.
//  - MEMWR: memwrite, iord=1; hold until memready; instr_done on memready cycle -> FETCH.
//  - RTEXEC: alusrca=1, alusrcb=00, aluop=100 -> RTWB.
//  - RTWB: regwrite, regdst=1, instr_done -> FETCH.
//  - BRANCH: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, pcen=zero, instr_done -> FETCH.
//  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=000 -> ADDIWB.
//  - ADDIWB: regwrite, regdst=0, instr_done -> FETCH.
//  - JUMP: pcen=1, pcsrc=10, instr_done -> FETCH.
//  - Zero-wait cycle counts: beq/j 3, R/addi/sw 4, lw 5; each memready-low cycle adds 1.
//  - Requests (memread/memwrite/iord) stay constant while waiting; no write enable besides
//    the memory request may fire in a wait cycle. memready ignored outside FETCH/MEMRD/MEMWR.
//  - Unused state encodings -> FETCH next cycle, outputs 0.
//  - rst_n mid-instruction aborts it; no instr_done; restart from RESET then FETCH.
// TESTING
//  - Reset: rst_n low mid-MEMRD -> all outputs 0 at once; release -> RESET, FETCH next.
//  - R-type, memready=1: FETCH,DECODE,RTEXEC(aluop=100),RTWB(regwrite,regdst=1,done) = 4 cy.
//  - lw, memready low 2 cy in FETCH and 3 cy in MEMRD -> 10 cy total; irwrite 1 cy only.
//  - beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; zero=0 -> pcen=0; both 3 cy.
//  - sw then j then addi back-to-back -> instr_done pulses at cycles 4, 7, 11.
//  - opcode 6'h3F -> illegal_op 1 cy in DECODE, no regwrite/memwrite/pcen, FETCH next.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory.
// The sequencer uses the master side; the datapath uses the slave side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       memready;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, memready, zero,
    output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op
  );

  modport slave (
    output opcode, memready, zero,
    input  pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle CPU: walks each instruction through
// fetch/decode/execute/memory/writeback and drives all datapath selects and enables.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_if.master        ctrl
);

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRd    = 4'd4,
    StMemWb    = 4'd5,
    StMemWr    = 4'd6,
    StRtExec   = 4'd7,
    StRtWb     = 4'd8,
    StBranch   = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StJump     = 4'd12
  } state_e;

  state_e r_state;
  state_e w_state_next;
  logic   w_pcwrite;
  logic   w_pcwritecond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StReset;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign ctrl.pcen = w_pcwrite | (w_pcwritecond & ctrl.zero);

  always_comb begin
    w_state_next    = StFetch;
    w_pcwrite       = 1'b0;
    w_pcwritecond   = 1'b0;
    ctrl.iord       = 1'b0;
    ctrl.memread    = 1'b0;
    ctrl.memwrite   = 1'b0;
    ctrl.irwrite    = 1'b0;
    ctrl.memtoreg   = 1'b0;
    ctrl.regdst     = 1'b0;
    ctrl.regwrite   = 1'b0;
    ctrl.alusrca    = 1'b0;
    ctrl.alusrcb    = 2'b00;
    ctrl.pcsrc      = 2'b00;
    ctrl.aluop      = 3'b000;
    ctrl.instr_done = 1'b0;
    ctrl.illegal_op = 1'b0;

    case (r_state)
      StReset: w_state_next = StFetch;
      StFetch: begin
        // PC+4 goes straight back into the PC in the same cycle the IR loads
        ctrl.memread = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = ctrl.memready;
        w_pcwrite    = ctrl.memready;
        w_state_next = ctrl.memready ? StDecode : StFetch;
      end
      StDecode: begin
        ctrl.alusrcb = 2'b11;
        case (ctrl.opcode)
          OP_RTYPE:     w_state_next = StRtExec;
          OP_LW, OP_SW: w_state_next = StMemAdr;
          OP_BEQ:       w_state_next = StBranch;
          OP_J:         w_state_next = StJump;
          OP_ADDI:      w_state_next = StAddiExec;
          default: begin
            ctrl.illegal_op = 1'b1;
            w_state_next    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        w_state_next = (ctrl.opcode == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        w_state_next = ctrl.memready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = ctrl.memready;
        w_state_next    = ctrl.memready ? StFetch : StMemWr;
      end
      StRtExec: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 3'b100;
        w_state_next = StRtWb;
      end
      StRtWb: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = 3'b001;
        ctrl.pcsrc      = 2'b01;
        w_pcwritecond   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StAddiExec: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        w_state_next = StAddiWb;
      end
      StAddiWb: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StJump: begin
        w_pcwrite       = 1'b1;
        ctrl.pcsrc      = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      default: w_state_next = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle scoreboard bench for the multi-cycle sequencer: the stimulus pushes the
// expected control word for each cycle, a negedge monitor pops and compares.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       done;
    logic       ill;
  } ctl_t;

  typedef struct {
    string nm;
    ctl_t  exp;
  } sb_item_t;

  localparam ctl_t ZERO   = '0;
  localparam ctl_t F_W    = '{memread: 1'b1, alusrcb: 2'b01, default: '0};
  localparam ctl_t F_GO   = '{pcen: 1'b1, memread: 1'b1, irwrite: 1'b1, alusrcb: 2'b01,
                              default: '0};
  localparam ctl_t DEC    = '{alusrcb: 2'b11, default: '0};
  localparam ctl_t DECILL = '{alusrcb: 2'b11, ill: 1'b1, default: '0};
  localparam ctl_t MADR   = '{alusrca: 1'b1, alusrcb: 2'b10, default: '0};
  localparam ctl_t MRD    = '{iord: 1'b1, memread: 1'b1, default: '0};
  localparam ctl_t MWB    = '{regwrite: 1'b1, memtoreg: 1'b1, done: 1'b1, default: '0};
  localparam ctl_t MWR_W  = '{iord: 1'b1, memwrite: 1'b1, default: '0};
  localparam ctl_t MWR_GO = '{iord: 1'b1, memwrite: 1'b1, done: 1'b1, default: '0};
  localparam ctl_t RTEX   = '{alusrca: 1'b1, aluop: 3'b100, default: '0};
  localparam ctl_t RTWB   = '{regwrite: 1'b1, regdst: 1'b1, done: 1'b1, default: '0};
  localparam ctl_t BR_T   = '{pcen: 1'b1, alusrca: 1'b1, pcsrc: 2'b01, aluop: 3'b001,
                              done: 1'b1, default: '0};
  localparam ctl_t BR_N   = '{alusrca: 1'b1, pcsrc: 2'b01, aluop: 3'b001, done: 1'b1,
                              default: '0};
  localparam ctl_t ADEX   = '{alusrca: 1'b1, alusrcb: 2'b10, default: '0};
  localparam ctl_t ADWB   = '{regwrite: 1'b1, done: 1'b1, default: '0};
  localparam ctl_t JMP    = '{pcen: 1'b1, pcsrc: 2'b10, done: 1'b1, default: '0};

  localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02,
                         ADDI = 6'h08, BAD = 6'h3F;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  bit   stim_done;
  sb_item_t sb_q[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus.master)
  );

  ctl_t act;
  assign act = '{pcen: bus.pcen, iord: bus.iord, memread: bus.memread,
                 memwrite: bus.memwrite, irwrite: bus.irwrite, memtoreg: bus.memtoreg,
                 regdst: bus.regdst, regwrite: bus.regwrite, alusrca: bus.alusrca,
                 alusrcb: bus.alusrcb, pcsrc: bus.pcsrc, aluop: bus.aluop,
                 done: bus.instr_done, ill: bus.illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input ctl_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; exp is the control word for the state entered at this edge.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr, input logic z,
                     input ctl_t exp, input string nm);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst_n        = rst;
    bus.opcode   = op;
    bus.memready = mr;
    bus.zero     = z;
    it.nm  = nm;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  // Monitor
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check(it.nm, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stim_done = 1'b0;
    rst_n = 1'b0;
    bus.opcode = '0;
    bus.memready = 1'b0;
    bus.zero = 1'b0;

    cyc(1'b0, RT, 1'b1, 1'b1, ZERO, "reset_hold");
    cyc(1'b1, RT, 1'b1, 1'b1, ZERO, "reset_release");

    // R-type, zero wait
    cyc(1'b1, RT, 1'b1, 1'b0, F_GO, "rt_fetch");
    cyc(1'b1, RT, 1'b0, 1'b0, DEC,  "rt_decode");
    cyc(1'b1, RT, 1'b0, 1'b0, RTEX, "rt_exec");
    cyc(1'b1, RT, 1'b0, 1'b0, RTWB, "rt_wb");

    // lw: 2 wait cycles in fetch, 3 in memrd -> 10 cycles
    cyc(1'b1, LW, 1'b0, 1'b0, F_W,  "lw_fetch_w1");
    cyc(1'b1, LW, 1'b0, 1'b1, F_W,  "lw_fetch_w2");
    cyc(1'b1, LW, 1'b1, 1'b0, F_GO, "lw_fetch");
    cyc(1'b1, LW, 1'b1, 1'b0, DEC,  "lw_decode");
    cyc(1'b1, LW, 1'b1, 1'b0, MADR, "lw_memadr");
    cyc(1'b1, LW, 1'b0, 1'b0, MRD,  "lw_memrd_w1");
    cyc(1'b1, LW, 1'b0, 1'b0, MRD,  "lw_memrd_w2");
    cyc(1'b1, LW, 1'b0, 1'b0, MRD,  "lw_memrd_w3");
    cyc(1'b1, LW, 1'b1, 1'b0, MRD,  "lw_memrd");
    cyc(1'b1, LW, 1'b0, 1'b0, MWB,  "lw_memwb");

    // beq taken / not taken
    cyc(1'b1, BEQ, 1'b1, 1'b0, F_GO, "beqt_fetch");
    cyc(1'b1, BEQ, 1'b0, 1'b0, DEC,  "beqt_decode");
    cyc(1'b1, BEQ, 1'b1, 1'b1, BR_T, "beqt_branch");
    cyc(1'b1, BEQ, 1'b1, 1'b1, F_GO, "beqn_fetch");
    cyc(1'b1, BEQ, 1'b0, 1'b1, DEC,  "beqn_decode");
    cyc(1'b1, BEQ, 1'b1, 1'b0, BR_N, "beqn_branch");

    // sw, j, addi back to back: done at cycles 4, 7, 11
    cyc(1'b1, SW,   1'b1, 1'b0, F_GO,   "sw_fetch");
    cyc(1'b1, SW,   1'b0, 1'b0, DEC,    "sw_decode");
    cyc(1'b1, SW,   1'b0, 1'b0, MADR,   "sw_memadr");
    cyc(1'b1, SW,   1'b1, 1'b0, MWR_GO, "sw_memwr");
    cyc(1'b1, J,    1'b1, 1'b0, F_GO,   "j_fetch");
    cyc(1'b1, J,    1'b0, 1'b0, DEC,    "j_decode");
    cyc(1'b1, J,    1'b0, 1'b0, JMP,    "j_jump");
    cyc(1'b1, ADDI, 1'b1, 1'b0, F_GO,   "addi_fetch");
    cyc(1'b1, ADDI, 1'b1, 1'b0, DEC,    "addi_decode");
    cyc(1'b1, ADDI, 1'b1, 1'b1, ADEX,   "addi_exec");
    cyc(1'b1, ADDI, 1'b1, 1'b1, ADWB,   "addi_wb");

    // sw with one memory wait cycle
    cyc(1'b1, SW, 1'b1, 1'b0, F_GO,   "sww_fetch");
    cyc(1'b1, SW, 1'b1, 1'b0, DEC,    "sww_decode");
    cyc(1'b1, SW, 1'b1, 1'b0, MADR,   "sww_memadr");
    cyc(1'b1, SW, 1'b0, 1'b1, MWR_W,  "sww_memwr_w");
    cyc(1'b1, SW, 1'b1, 1'b0, MWR_GO, "sww_memwr");

    // illegal opcode
    cyc(1'b1, BAD, 1'b1, 1'b1, F_GO,   "ill_fetch");
    cyc(1'b1, BAD, 1'b1, 1'b1, DECILL, "ill_decode");
    cyc(1'b1, RT,  1'b0, 1'b0, F_W,    "ill_next_fetch");
    cyc(1'b1, RT,  1'b1, 1'b0, F_GO,   "ill_next_fetch_go");
    cyc(1'b1, RT,  1'b0, 1'b0, DEC,    "ill_next_decode");
    cyc(1'b1, RT,  1'b0, 1'b0, RTEX,   "ill_next_exec");
    cyc(1'b1, RT,  1'b0, 1'b0, RTWB,   "ill_next_wb");

    // reset mid-MEMRD: outputs drop immediately, no done
    cyc(1'b1, LW, 1'b1, 1'b0, F_GO, "rst_lw_fetch");
    cyc(1'b1, LW, 1'b0, 1'b0, DEC,  "rst_lw_decode");
    cyc(1'b1, LW, 1'b0, 1'b0, MADR, "rst_lw_memadr");
    cyc(1'b1, LW, 1'b0, 1'b0, MRD,  "rst_lw_memrd");
    @(posedge clk);
    #2;
    check("rst_pre_assert", MRD);
    rst_n = 1'b0;
    bus.memready = 1'b1;
    #1;
    check("rst_async_zero", ZERO);
    cyc(1'b0, LW, 1'b1, 1'b0, ZERO, "rst_hold2");
    cyc(1'b1, LW, 1'b1, 1'b0, ZERO, "rst_release2");
    cyc(1'b1, RT, 1'b0, 1'b0, F_W,  "rst_then_fetch");

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d left required 0", sb_q.size());
    end
    stim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
